// File: rtl/apb4_pkg.sv
// apb4_pkg: shared FSM state encoding and APB protection bit positions.
package apb4_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
   localparam int PROT_PRIV  = 0;
   localparam int PROT_NSEC  = 1;
   localparam int PROT_INSTR = 2;
endpackage

// File: rtl/apb4_slv_decode.sv
// apb4_slv_decode: address-to-slave one-hot select and per-slave response mux.
module apb4_slv_decode #(
   parameter int APB_AW  = 32,
   parameter int APB_DW  = 32,
   parameter int NUM_SLV = 4
) (
   input  logic [APB_AW-1:0]         addr,
   input  logic [NUM_SLV*APB_DW-1:0] prdata,
   input  logic [NUM_SLV-1:0]        pready,
   input  logic [NUM_SLV-1:0]        pslverr,
   output logic [NUM_SLV-1:0]        sel,
   output logic                      rdy,
   output logic                      err,
   output logic [APB_DW-1:0]         rdata
);
   localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
   logic [IW-1:0] idx;
   logic          unused_addr;
   assign unused_addr = ^addr;
   generate
      if (NUM_SLV > 1) begin : g_idx
         assign idx = addr[APB_AW-1 -: IW];
      end else begin : g_one
         assign idx = '0;
      end
   endgenerate
   // Only the addressed slave's signals reach the requester.
   always_comb begin
      sel   = '0;
      rdy   = 1'b0;
      err   = 1'b0;
      rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx == IW'(i)) begin
            sel[i] = 1'b1;
            rdy    = pready[i];
            err    = pslverr[i];
            rdata  = prdata[i*APB_DW +: APB_DW];
         end
      end
   end
endmodule

// File: rtl/apb4_requester.sv
// apb4_requester: single-outstanding APB4 requester with per-slave decode
// and an optional ACCESS-phase wait timeout.
module apb4_requester
   import apb4_pkg::*;
#(
   parameter int APB_AW  = 32,
   parameter int APB_DW  = 32,
   parameter int NUM_SLV = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [APB_AW-1:0]         req_addr,
   input  logic                      req_write,
   input  logic [APB_DW-1:0]         req_wdata,
   input  logic [APB_DW/8-1:0]       req_strb,
   input  logic [2:0]                req_prot,
   output logic                      rsp_valid,
   output logic [APB_DW-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic [APB_AW-1:0]         paddr,
   output logic [NUM_SLV-1:0]        psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [APB_DW-1:0]         pwdata,
   output logic [APB_DW/8-1:0]       pstrb,
   output logic [2:0]                pprot,
   input  logic [NUM_SLV*APB_DW-1:0] prdata,
   input  logic [NUM_SLV-1:0]        pready,
   input  logic [NUM_SLV-1:0]        pslverr
);
   localparam int SW = APB_DW/8;
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT+1) : 1;
   apb_state_e          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [APB_AW-1:0]   paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [APB_DW-1:0]   pwdata_q, pwdata_d;
   logic [SW-1:0]       pstrb_q, pstrb_d;
   logic [2:0]          pprot_q, pprot_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [APB_DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic [NUM_SLV-1:0]  sel;
   logic                rdy, err, accept, in_access, hit;
   logic [APB_DW-1:0]   rdata;

   apb4_slv_decode #(.APB_AW(APB_AW), .APB_DW(APB_DW), .NUM_SLV(NUM_SLV)) u_dec (
      .addr(paddr_q), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .sel(sel), .rdy(rdy), .err(err), .rdata(rdata)
   );

   assign accept    = (state_q == IDLE) && req_valid;
   assign in_access = state_q == ACCESS;
   // A late pready on the final allowed cycle completes normally.
   assign hit       = (TIMEOUT > 0) && in_access && !rdy && (cnt_q == CW'(TIMEOUT-1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         pprot_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         pprot_q       <= pprot_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   always_comb begin
      state_d = state_q == IDLE  ? (req_valid ? SETUP : IDLE) :
                state_q == SETUP ? ACCESS :
                (rdy || hit)     ? IDLE : ACCESS;
   end

   always_comb begin
      paddr_d       = accept ? req_addr : paddr_q;
      pwrite_d      = accept ? req_write : pwrite_q;
      pwdata_d      = accept ? req_wdata : pwdata_q;
      pstrb_d       = accept ? (req_write ? req_strb : '0) : pstrb_q;
      pprot_d       = accept ? req_prot : pprot_q;
      cnt_d         = (in_access && !rdy && !hit) ? cnt_q + CW'(1) : '0;
      rsp_valid_d   = in_access && (rdy || hit);
      rsp_rdata_d   = (in_access && rdy && !pwrite_q) ? rdata : '0;
      rsp_err_d     = in_access && (rdy ? err : hit);
      rsp_timeout_d = hit;
   end

   always_comb begin
      req_ready = state_q == IDLE;
      psel      = (state_q != IDLE) ? sel : '0;
      penable   = in_access;
   end

   assign paddr       = paddr_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign pstrb       = pstrb_q;
   assign pprot       = pprot_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
endmodule
